// File: rtl/pipeline_pkg.sv
// Shared RV32I-subset pipeline definitions: opcodes, ALU control, result select, immediate format.
package pipeline_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

endpackage

// File: rtl/idecode_regfile.sv
// Register file, 2 async read ports + 1 write port; x0 reads zero, write data bypasses to reads.
// Write commits on the rising edge; no backpressure.
module regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   // A matching write index implies a nonzero index here, so x0 is never bypassed.
   assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];

endmodule

// File: rtl/idecode.sv
// Decode stage: control decode, register read with write-back bypass, immediate extend, ID/EX register.
// Latency 1 cycle to the *E outputs; no stall, FlushE loads a bubble.
module idecode
   import pipeline_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [4:0]      rd;
   logic            reg_write, mem_write, branch, jump, alu_src;
   result_src_t     result_src;
   imm_src_t        imm_src;
   alu_ctrl_t       alu_ctrl;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] rd1, rd2;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7b5 = InstrD[30];
   assign rd       = InstrD[11:7];
   assign Rs1D     = InstrD[19:15];
   assign Rs2D     = InstrD[24:20];

   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      alu_src    = 1'b0;
      result_src = RES_ALU;
      imm_src    = IMM_I;
      case (opcode)
         OP_LW:  begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
         OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
         OP_R:   reg_write = 1'b1;
         OP_I:   begin reg_write = 1'b1; alu_src = 1'b1; end
         OP_BEQ: begin branch = 1'b1; imm_src = IMM_B; end
         OP_JAL: begin reg_write = 1'b1; jump = 1'b1; result_src = RES_PC4; imm_src = IMM_J; end
         default: ;
      endcase
   end

   // Unknown opcodes fall through to add, so a NOP carries all-zero control.
   always_comb begin
      alu_ctrl = ALU_ADD;
      if (opcode == OP_BEQ) begin
         alu_ctrl = ALU_SUB;
      end else if (opcode == OP_R || opcode == OP_I) begin
         case (funct3)
            3'b000:  alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
         endcase
      end
   end

   always_comb begin
      imm_ext = '0;
      case (imm_src)
         IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B: imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                           InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J: imm_ext = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                           InstrD[20], InstrD[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk   (clk),
      .reset (reset),
      .ra1   (Rs1D),
      .ra2   (Rs2D),
      .we    (RegWriteW),
      .wa    (RdW),
      .wd    (ResultW),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || FlushE) begin
         RD1E        <= '0;
         RD2E        <= '0;
         PCE         <= '0;
         ImmExtE     <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
      end else begin
         RD1E        <= rd1;
         RD2E        <= rd2;
         PCE         <= PCD;
         ImmExtE     <= imm_ext;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= rd;
         RegWriteE   <= reg_write;
         MemWriteE   <= mem_write;
         JumpE       <= jump;
         BranchE     <= branch;
         ALUSrcE     <= alu_src;
         ResultSrcE  <= result_src;
         ALUControlE <= alu_ctrl;
      end
   end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: decode vector table, hand sequences for bypass/flush/reset, random vs architectural model.
module tb_idecode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RdW, Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;

   always #5 clk = ~clk;

   idecode dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
      .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
   );

   typedef struct packed {
      logic [31:0] rd1, rd2, pc, imm, pcp4;
      logic [4:0]  rs1, rs2, rd;
      logic        regw, memw, jump, branch, alusrc;
      logic [1:0]  ressrc;
      logic [2:0]  aluc;
   } eout_t;

   eout_t got_e;
   assign got_e = {RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
                   RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] mregs [32];

   task automatic check(input string name, input logic [184:0] got, input logic [184:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Assemblers
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   // Architectural model: immediates as signed integer offsets, registers read from mregs.
   function automatic eout_t model(input logic [31:0] instr, input logic [31:0] pc, input logic flush);
      eout_t e = '0;
      int    f3, imm;
      string cls;
      if (flush) return e;
      e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7];
      e.rd1 = (e.rs1 == 0) ? 32'd0 : mregs[e.rs1];
      e.rd2 = (e.rs2 == 0) ? 32'd0 : mregs[e.rs2];
      e.pc = pc; e.pcp4 = pc + 32'd4;
      f3 = int'(instr[14:12]);
      imm = 0;
      case (instr[6:0])
         7'b0000011: cls = "lw";
         7'b0100011: cls = "sw";
         7'b0110011: cls = "r";
         7'b0010011: cls = "i";
         7'b1100011: cls = "beq";
         7'b1101111: cls = "jal";
         default:    cls = "nop";
      endcase
      if (cls == "lw" || cls == "i")
         imm = int'(instr[30:20]) - int'(instr[31]) * 2048;
      else if (cls == "sw")
         imm = int'(instr[30:25]) * 32 + int'(instr[11:7]) - int'(instr[31]) * 2048;
      else if (cls == "beq")
         imm = int'(instr[11:8]) * 2 + int'(instr[30:25]) * 32 + int'(instr[7]) * 2048
               - int'(instr[31]) * 4096;
      else if (cls == "jal")
         imm = int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096
               - int'(instr[31]) * 1048576;
      e.imm = imm;
      e.regw   = (cls == "lw" || cls == "r" || cls == "i" || cls == "jal");
      e.memw   = (cls == "sw");
      e.jump   = (cls == "jal");
      e.branch = (cls == "beq");
      e.alusrc = (cls == "lw" || cls == "sw" || cls == "i");
      e.ressrc = (cls == "lw") ? 2'b01 : (cls == "jal") ? 2'b10 : 2'b00;
      e.aluc   = 3'b000;
      if (cls == "beq") e.aluc = 3'b001;
      else if (cls == "r" || cls == "i") begin
         if (f3 == 0 && cls == "r" && instr[30]) e.aluc = 3'b001;
         else if (f3 == 2) e.aluc = 3'b101;
         else if (f3 == 6) e.aluc = 3'b011;
         else if (f3 == 7) e.aluc = 3'b010;
      end
      return e;
   endfunction

   // Apply one cycle: write-back is modelled as committing before the same-cycle read.
   task automatic apply(input string name, input logic [31:0] instr, pc,
                        input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                        input logic flush);
      eout_t exp, mask;
      InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      RegWriteW = rw; RdW = rdw; ResultW = resw; FlushE = flush;
      #1;
      check({name, "_rsD"}, 185'({Rs1D, Rs2D}), 185'({instr[19:15], instr[24:20]}));
      if (rw && rdw != 0) mregs[rdw] = resw;
      exp  = model(instr, pc, flush);
      mask = '1;
      // R-type and unknown opcodes have no immediate; its value is unconstrained.
      if (!flush && instr[6:0] != 7'b0000011 && instr[6:0] != 7'b0100011 &&
          instr[6:0] != 7'b0010011 && instr[6:0] != 7'b1100011 && instr[6:0] != 7'b1101111)
         mask.imm = '0;
      @(posedge clk);
      #1;
      check(name, got_e & mask, exp & mask);
   endtask

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        flush;
      logic [4:0]  rd;
      logic        chk_imm;
      logic [31:0] imm;
      logic [9:0]  ctrl; // regw memw jump branch alusrc ressrc[1:0] aluc[2:0]
   } vec_t;

   vec_t vt[12];

   initial begin
      vt[0]  = '{"lw_neg4",  32'hFFC12383,                    1'b0, 5'd7,  1'b1, 32'hFFFFFFFC, 10'b1_0_0_0_1_01_000};
      vt[1]  = '{"beq_m8",   enc_b(13'h1FF8, 5'd2, 5'd1),      1'b0, 5'd25, 1'b1, 32'hFFFFFFF8, 10'b0_0_0_1_0_00_001};
      vt[2]  = '{"jal_2048", enc_j(21'h000800, 5'd1),          1'b0, 5'd1,  1'b1, 32'h00000800, 10'b1_0_1_0_0_10_000};
      vt[3]  = '{"sw_flush", enc_s(12'h010, 5'd3, 5'd2),       1'b1, 5'd0,  1'b1, 32'h0,        10'b0};
      vt[4]  = '{"illegal",  32'h0000007F,                     1'b0, 5'd0,  1'b1, 32'h0,        10'b0};
      vt[5]  = '{"sw_neg",   enc_s(12'hFF0, 5'd3, 5'd2),       1'b0, 5'd16, 1'b1, 32'hFFFFFFF0, 10'b0_1_0_0_1_00_000};
      vt[6]  = '{"sub",      enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 1'b0, 5'd4, 1'b0, 32'h0,    10'b1_0_0_0_0_00_001};
      vt[7]  = '{"slti",     enc_i(12'hFFF, 5'd1, 3'd2, 5'd5), 1'b0, 5'd5,  1'b1, 32'hFFFFFFFF, 10'b1_0_0_0_1_00_101};
      vt[8]  = '{"ori",      enc_i(12'h7FF, 5'd1, 3'd6, 5'd6), 1'b0, 5'd6,  1'b1, 32'h000007FF, 10'b1_0_0_0_1_00_011};
      vt[9]  = '{"and",      enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd7), 1'b0, 5'd7, 1'b0, 32'h0,    10'b1_0_0_0_0_00_010};
      vt[10] = '{"addi_b30", enc_i(12'h400, 5'd1, 3'd0, 5'd8), 1'b0, 5'd8,  1'b1, 32'h00000400, 10'b1_0_0_0_1_00_000};
      vt[11] = '{"sll_add",  enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd9), 1'b0, 5'd9, 1'b0, 32'h0,    10'b1_0_0_0_0_00_000};

      for (int i = 0; i < 32; i++) mregs[i] = '0;
      reset = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
      RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
      #2;
      check("reset_state", got_e, '0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;

      // Seed registers, then the decode table.
      apply("seed_x1", 32'h0000007F, 32'h100, 1'b1, 5'd1, 32'h11111111, 1'b0);
      apply("seed_x2", 32'h0000007F, 32'h104, 1'b1, 5'd2, 32'h22222222, 1'b0);
      for (int i = 0; i < 12; i++) begin
         apply(vt[i].name, vt[i].instr, 32'h200 + 32'(i * 4), 1'b0, 5'd0, 32'h0, vt[i].flush);
         check({vt[i].name, "_tbl"},
               185'({RdE, (vt[i].chk_imm ? ImmExtE : 32'h0), got_e[9:0]}),
               185'({vt[i].rd, vt[i].imm, vt[i].ctrl}));
      end

      // Same-cycle write-back bypass.
      apply("bypass_x5", enc_i(12'h0, 5'd5, 3'd0, 5'd9), 32'h300, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
      check("bypass_x5_rd1", 185'(RD1E), 185'(32'hDEADBEEF));
      // Writes to x0 are dropped and never bypassed.
      apply("x0_write", enc_r(7'h0, 5'd0, 5'd0, 3'd0, 5'd3), 32'h304, 1'b1, 5'd0, 32'h1234, 1'b0);
      check("x0_bypass_rd1", 185'({RD1E, RD2E}), 185'(0));
      apply("x0_read", enc_i(12'h0, 5'd0, 3'd0, 5'd3), 32'h308, 1'b0, 5'd0, 32'h0, 1'b0);
      check("x0_read_rd1", 185'(RD1E), 185'(0));
      // Flush does not block the register file write.
      apply("flush_wr", enc_s(12'h0, 5'd1, 5'd2), 32'h30C, 1'b1, 5'd10, 32'hA5A5A5A5, 1'b1);
      apply("flush_rd", enc_r(7'h0, 5'd10, 5'd10, 3'd0, 5'd11), 32'h310, 1'b0, 5'd0, 32'h0, 1'b0);
      check("flush_rd_rd2", 185'(RD2E), 185'(32'hA5A5A5A5));

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ins;
         logic [6:0]  ops [7];
         logic [4:0]  rdw;
         ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
         ins = $urandom;
         ins[6:0] = ($urandom_range(0, 6) == 6) ? 7'($urandom) : ops[$urandom_range(0, 5)];
         rdw = ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom);
         apply("rand", ins, $urandom, 1'($urandom), rdw, $urandom, ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset mid-run, away from the clock edge.
      #3 reset = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      #1 check("reset_async", got_e, '0);
      @(posedge clk); #1;
      check("reset_held", got_e, '0);
      #2 reset = 1'b1;
      #1;
      apply("post_reset_add", enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3), 32'h400, 1'b0, 5'd0, 32'h0, 1'b0);
      check("post_reset_add_tbl", 185'({RD1E, RD2E, ALUControlE, RdE}), 185'({64'h0, 3'b000, 5'd3}));
      for (int r = 1; r < 32; r += 2) begin
         logic [4:0] a, b;
         a = 5'(r);
         b = (r == 31) ? 5'd31 : 5'(r + 1);
         apply("cleared_regs", enc_r(7'h0, b, a, 3'd0, 5'd0), 32'h500, 1'b0, 5'd0, 32'h0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/idecode.md
# idecode

Decode stage of the five-stage RV32I-subset pipeline, sitting between the IF/ID register and the execute stage. It decodes `InstrD` into control signals, reads and writes the 32×32 register file (with a write-back bypass), and sign-extends the immediate. It also owns the ID/EX pipeline register, which drives the `*E` inputs of execute. The hazard unit flushes that register to insert a bubble.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREGS`, 32, architectural register count (x0 hardwired zero)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears register file and ID/EX register
- `InstrD`  in  32  instruction from IF/ID
- `PCD`, `PCPlus4D`  in  32  PC and PC+4 from IF/ID
- `RegWriteW`  in  1  write-back enable
- `RdW`  in  5  write-back destination
- `ResultW`  in  32  write-back data
- `FlushE`  in  1  hazard unit: load bubble into ID/EX on next edge
- `Rs1D`, `Rs2D`  out  5  source indices to hazard unit (combinational)
- `RD1E`, `RD2E`, `PCE`, `ImmExtE`, `PCPlus4E`  out  32  registered operands
- `Rs1E`, `Rs2E`, `RdE`  out  5  registered indices (forwarding unit, EX/MEM)
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1  registered control
- `ResultSrcE`  out  2  00 ALU, 01 memory, 10 PC+4
- `ALUControlE`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

## Operation
- Field extraction: `Rs1D=InstrD[19:15]`, `Rs2D=InstrD[24:20]`, `RdD=InstrD[11:7]`.
- Opcode decode (main decoder):
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, imm I
  - sw 0100011: MemWrite, ALUSrc, imm S
  - R-type 0110011: RegWrite
  - I-ALU 0010011: RegWrite, ALUSrc, imm I
  - beq 1100011: Branch, ALU sub, imm B
  - jal 1101111: RegWrite, Jump, ResultSrc=10, imm J
  - Any other opcode: all control zero, a NOP. No trap is raised.
- ALU decoder:
  - lw, sw and jal → add; beq → sub.
  - R/I-type funct3 000 → add, except R-type with `funct7[5]=1` → sub.
  - funct3 010 → slt, 110 → or, 111 → and.
  - Other funct3 → add.
- Immediate generation: every immediate is sign-extended from `InstrD[31]`; B and J immediates have bit 0 = 0.
  - I: `InstrD[31:20]`
  - S: `{InstrD[31:25], InstrD[11:7]}`
  - B: `{[31],[7],[30:25],[11:8],0}`
  - J: `{[31],[19:12],[20],[30:21],0}`
- Register file write: on a rising edge when `RegWriteW` is high and `RdW≠0`, `ResultW` is written.
- Register file read:
  - x0 always reads 0.
  - Same-cycle bypass: if `RegWriteW`, `RdW≠0` and `RdW==Rs1D`, then RD1 = `ResultW` combinationally. RD2 behaves the same way with `Rs2D`.
  - Reading rs=x0 returns 0 even when `RdW==0`.
- ID/EX register:
  - On each rising edge it captures decoded control, RD1, RD2, `PCD`, `ImmExt`, `PCPlus4D`, `Rs1D`, `Rs2D` and `RdD`.
  - If `FlushE=1`, every `*E` output loads 0 instead (a bubble: no RegWrite, MemWrite, Branch or Jump).

## Timing
- Reset (asynchronous assert, clock-independent):
  - All 31 writable registers clear to 0.
  - Every `*E` output clears to 0.
  - `Rs1D` and `Rs2D` remain combinational from `InstrD`.
- Decode-to-execute latency: exactly 1 cycle, with no internal stall. Upstream stalling is done by holding IF/ID; execute then sees repeated or flushed contents.
- Write-back vs read in the same cycle: the bypass makes the new value visible in ID/EX on that same edge. Software never needs a 3-cycle gap.
- `FlushE` and `RegWriteW` together: the register file write still commits; only ID/EX is zeroed.
- Reset released mid-stream: the first edge after deassertion captures the current `InstrD` normally.

## Structure
- Shared package `pipeline_pkg` holds:
  - opcode constants
  - `alu_ctrl_t` (3-bit ALUControl encoding)
  - `result_src_t` (2-bit)
  - `imm_src_t` enum (I, S, B, J)
- Execute and the control decoder both import it.
- Sub-module: `regfile`, containing the 2 read ports, 1 write port, x0 hardwiring, bypass and asynchronous reset.
- Decoders, immediate generation and the ID/EX register stay in `idecode`.

## Test plan
1. Reset low mid-run → all `*E` outputs and x1..x31 read 0 immediately. After release, `add x3,x1,x2` produces `RD1E=RD2E=0`, `ALUControlE=000`, `RdE=3`.
2. Write x5=0xDEADBEEF via `RegWriteW` while `InstrD` reads rs1=x5 in the same cycle → `RD1E=0xDEADBEEF` on the next edge.
3. `RdW=0`, `ResultW=0x1234`, `RegWriteW=1`, then read x0 → `RD1E=0`.
4. `lw x7,-4(x2)` (0xFFC12383) → `ImmExtE=0xFFFFFFFC`, `ResultSrcE=01`, `ALUSrcE=1`, `RegWriteE=1`, `RdE=7`.
5. `beq` with offset −8, and `jal` with offset +2048 → `ImmExtE=0xFFFFFFF8`, `BranchE=1`, `ALUControlE=001`; then `ImmExtE=0x00000800`, `JumpE=1`, `ResultSrcE=10`.
6. `sw` with `FlushE=1` → all `*E` outputs 0. Illegal opcode 0x0000007F → all control outputs 0.
